// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
package ps2_pkg;

    typedef logic [3:0] state_t;

    localparam state_t IDLE       = 4'd0;
    localparam state_t INHIBIT    = 4'd1;
    localparam state_t RTS        = 4'd2;
    localparam state_t WAIT_START = 4'd3;
    localparam state_t SHIFT      = 4'd4;
    localparam state_t WAIT_ACK   = 4'd5;
    localparam state_t WAIT_IDLE  = 4'd6;
    localparam state_t DONE       = 4'd7;
    localparam state_t ERROR      = 4'd8;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    // Device falling edges in one host-to-device frame, ACK edge included.
    localparam int PS2_FRAME_EDGES = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - synchronizer, glitch filter and clock fall strobe for both PS/2 lines
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_filt,
    output logic data_filt,
    output logic clk_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(FILTER_LEN - 1);

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [CW-1:0] cnt [2];

    // Two-flop synchronizer, then a level is only accepted after FILTER_LEN
    // consecutive samples disagree with the current filtered value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
            clk_fall <= 1'b0;
        end else begin
            sync1    <= {ps2_data_in, ps2_clk_in};
            sync2    <= sync1;
            clk_fall <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TC) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                    if (i == 0 && !sync2[i]) clk_fall <= 1'b1;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign clk_filt  = filt[0];
    assign data_filt = filt[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int FRAME_TIMEOUT_CYCLES = 200000,
    parameter int FILTER_LEN           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // Terminal counts: the counter holds 0..N-1 during an N-cycle stay.
    localparam logic [20:0] INH_TC   = 21'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] START_TC = 21'(START_TIMEOUT_CYCLES - 1);
    localparam logic [20:0] FRAME_TC = 21'(FRAME_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_EDGES - 2);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  err_nx;
    logic [20:0] cnt;
    logic [8:0]  shreg;
    logic [3:0]  bit_cnt;
    logic        clk_oe_q;
    logic        data_oe_q;
    logic [1:0]  err_code_q;
    logic        clk_filt;
    logic        data_filt;
    logic        clk_fall;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_filt   (clk_filt),
        .data_filt  (data_filt),
        .clk_fall   (clk_fall)
    );

    // Next-state logic; a timeout wins over a coincident falling edge.
    always_comb begin
        state_nx = state;
        err_nx   = ERR_NONE;
        case (state)
            IDLE:       if (tx_valid) state_nx = INHIBIT;
            INHIBIT:    if (cnt == INH_TC) state_nx = RTS;
            RTS:        state_nx = WAIT_START;
            WAIT_START: begin
                if (cnt == START_TC) begin
                    state_nx = ERROR;
                    err_nx   = ERR_START;
                end else if (clk_fall) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == FRAME_TC) begin
                    state_nx = ERROR;
                    err_nx   = ERR_FRAME;
                end else if (clk_fall && bit_cnt == LAST_BIT) begin
                    state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (cnt == FRAME_TC) begin
                    state_nx = ERROR;
                    err_nx   = ERR_FRAME;
                end else if (clk_fall) begin
                    if (data_filt) begin
                        state_nx = ERROR;
                        err_nx   = ERR_NOACK;
                    end else begin
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (cnt == FRAME_TC) begin
                    state_nx = ERROR;
                    err_nx   = ERR_FRAME;
                end else if (clk_filt && data_filt) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            ERROR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register and the shared saturating counter, cleared on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) cnt <= '0;
            else if (cnt != '1)    cnt <= cnt + 21'd1;
        end
    end

    // Frame shifter and line drivers; data only moves in the cycle after a clock fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg     <= {odd_parity(tx_data), tx_data};
                        bit_cnt   <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                    end
                end
                INHIBIT: if (state_nx == RTS) data_oe_q <= 1'b1;
                RTS:     clk_oe_q <= 1'b0;
                WAIT_START: begin
                    if (state_nx == SHIFT) begin
                        data_oe_q <= ~shreg[0];
                        shreg     <= {1'b1, shreg[8:1]};
                        bit_cnt   <= 4'd1;
                    end
                end
                SHIFT: begin
                    if (state_nx == WAIT_ACK) begin
                        data_oe_q <= 1'b0;
                        bit_cnt   <= bit_cnt + 4'd1;
                    end else if (state_nx == SHIFT && clk_fall) begin
                        data_oe_q <= ~shreg[0];
                        shreg     <= {1'b1, shreg[8:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                end
                WAIT_ACK: if (state_nx == WAIT_IDLE) bit_cnt <= bit_cnt + 4'd1;
                default: ;
            endcase
            if (state_nx == ERROR) begin
                clk_oe_q   <= 1'b0;
                data_oe_q  <= 1'b0;
                err_code_q <= err_nx;
            end
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign tx_done     = (state == DONE);
    assign tx_error    = (state == ERROR);
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx
module tb_ps2_host_tx;

    localparam int INH   = 20;
    localparam int START = 300;
    localparam int FRAME = 2000;
    localparam int H     = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    // Open-drain lines: low if either side pulls.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START),
        .FRAME_TIMEOUT_CYCLES(FRAME),
        .FILTER_LEN          (4)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int ready_bad = 0;
    int t0 = -1;
    logic track = 1'b0;
    logic in_xfer = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       glitch;
        logic [8:0] frame;
        int         n_done;
        int         n_err;
        logic [1:0] code;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (tx_done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (in_xfer && tx_ready) ready_bad++;
        if (tx_done || tx_error) in_xfer = 1'b0;
        if (track && t0 < 0 && !ps2_data_oe) t0 = cyc;
    endtask

    task automatic start_send(input logic [7:0] d, output int inh_len, output int rts_len);
        step();
        check("ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        in_xfer  = 1'b1;
        check("busy_after_accept", busy, 1);
        inh_len = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh_len < INH + 50) begin
            inh_len++;
            step();
        end
        rts_len = 0;
        while (ps2_clk_oe && ps2_data_oe && rts_len < 10) begin
            rts_len++;
            step();
        end
    endtask

    // One device clock period: high half (optionally with a 2-cycle glitch), then low half.
    task automatic dev_edge(input logic glitch, output logic smp);
        for (int i = 0; i < H; i++) begin
            if (glitch && i == H / 2)     dev_clk = 1'b0;
            if (glitch && i == H / 2 + 2) dev_clk = 1'b1;
            step();
        end
        dev_clk = 1'b0;
        for (int i = 0; i < H; i++) step();
        smp = ~ps2_data_oe;
        dev_clk = 1'b1;
    endtask

    task automatic run_vector(input vec_t v);
        int inh_len, rts_len, d0, e0;
        logic [9:0] bits;
        logic dummy;
        start_send(v.data, inh_len, rts_len);
        check("inhibit_len", inh_len, INH);
        check("rts_len", rts_len, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        for (int e = 0; e < 10; e++) dev_edge(v.glitch, bits[e]);
        dev_data = ~v.ack;
        dev_edge(v.glitch, dummy);
        dev_data = 1'b1;
        for (int i = 0; i < 100 && done_cnt == d0 && err_cnt == e0; i++) step();
        check("frame_bits", bits[8:0], v.frame);
        check("stop_released", bits[9], 1);
        check("done_pulses", done_cnt - d0, v.n_done);
        check("error_pulses", err_cnt - e0, v.n_err);
        check("err_code", err_code, v.code);
        check("ready_low_in_xfer", ready_bad, 0);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        int inh_len, rts_len, n, d0, e0;
        logic dummy;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 9'h1ED, 1, 0, 2'b00};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 9'h001, 1, 0, 2'b00};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 9'h100, 1, 0, 2'b00};
        vecs[3] = '{8'hF4, 1'b0, 1'b0, 9'h0F4, 0, 1, 2'b11};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 9'h1FF, 1, 0, 2'b11};

        // Reset state
        step();
        step();
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_done, tx_error}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        rst_n = 1'b1;
        step();

        // Table of complete transfers, back to back
        for (int i = 0; i < 5; i++) run_vector(vecs[i]);

        // Device never clocks: start timeout counted from clock release
        start_send(8'hF4, inh_len, rts_len);
        check("st_release_seen", ps2_clk_oe, 0);
        d0 = done_cnt;
        e0 = err_cnt;
        n = 0;
        while (err_cnt == e0 && n < START + 50) begin
            step();
            n++;
        end
        check("start_timeout_cycles", n, START);
        check("start_err_code", err_code, 2'b01);
        check("start_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        check("start_no_done", done_cnt - d0, 0);

        // Device stops after 5 edges: frame timeout counted from the first shifted bit
        start_send(8'hFF, inh_len, rts_len);
        t0 = -1;
        track = 1'b1;
        e0 = err_cnt;
        for (int e = 0; e < 5; e++) dev_edge(1'b0, dummy);
        for (int i = 0; i < FRAME + 100 && err_cnt == e0; i++) step();
        track = 1'b0;
        check("frame_timeout_cycles", err_cyc - t0, FRAME);
        check("frame_err_code", err_code, 2'b10);
        check("frame_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);

        // Reset at edge 6 of 0xFF with glitches on the clock line
        start_send(8'hFF, inh_len, rts_len);
        d0 = done_cnt;
        e0 = err_cnt;
        for (int e = 0; e < 5; e++) dev_edge(1'b1, dummy);
        for (int i = 0; i < H; i++) step();
        dev_clk = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        in_xfer = 1'b0;
        #1;
        check("edge6_reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        step();
        step();
        dev_clk = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("edge6_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        check("edge6_idle", {tx_ready, busy}, 2'b10);

        // Reset asserted between clock edges during INHIBIT drops the clock line at once
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        step();
        check("inhibit_clk_oe", ps2_clk_oe, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        step();
        rst_n = 1'b1;
        step();
        check("async_reset_idle", tx_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It is the outbound counterpart of the PS/2 keyboard receiver that drives the move_up/down/left/right inputs of the VGA controller. It drives the PS/2 clock and data lines open-drain; the top level converts the *_oe and *_in pairs into the `inout ps2_clk` / `inout ps2_data` pins by assigning the pin 1'b0 when *_oe is high, else 1'bz.

Parameters:
INHIBIT_CYCLES, 10000, number of clk cycles ps2_clk is held low before request-to-send (100 us at 100 MHz).
START_TIMEOUT_CYCLES, 1500000, maximum cycles from clock release to the first device falling edge (15 ms).
FRAME_TIMEOUT_CYCLES, 200000, maximum cycles from the first falling edge to ACK completion (2 ms).
FILTER_LEN, 4, number of consecutive equal synchronized samples required before a line level is accepted.

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-low reset
tx_valid  in  1  request to send tx_data
tx_data  in  8  command byte
tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready
busy  out  1  high in any state other than IDLE
tx_done  out  1  one-cycle pulse when ACK is received and both lines are back high
tx_error  out  1  one-cycle pulse when a transfer is aborted
err_code  out  2  valid when tx_error is high: 01 start timeout, 10 frame timeout, 11 no ACK; holds its value until the next error
ps2_clk_in  in  1  raw PS/2 clock line level
ps2_data_in  in  1  raw PS/2 data line level
ps2_clk_oe  out  1  1 = pull ps2_clk low
ps2_data_oe  out  1  1 = pull ps2_data low

Behaviour:
- Reset values: tx_ready=1, busy=0, tx_done=0, tx_error=0, err_code=00, ps2_clk_oe=0, ps2_data_oe=0, state=IDLE.
- Asserting reset at any point in a transfer releases both lines immediately (asynchronous). No tx_done or tx_error is emitted for the killed transfer.
- Input conditioning: 2-FF synchronizer, then the FILTER_LEN glitch filter. fall_edge is a one-cycle strobe on a filtered 1->0 transition of the clock line. Input-to-strobe latency is 2+FILTER_LEN cycles.
- On accept:
  - latch tx_data;
  - compute parity = ~^tx_data (odd parity);
  - bit_cnt=0, cycle counter=0.
- tx_valid is ignored while busy.
- States and transitions:
  - IDLE: on accept -> INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0; after INHIBIT_CYCLES cycles -> RTS.
  - RTS: clk_oe=1, data_oe=1 for exactly 1 cycle, then clk_oe=0 -> WAIT_START; counter reset.
  - WAIT_START: data_oe=1. First fall_edge -> SHIFT and drive data bit0 (data_oe = ~bit0); counter reset, bit_cnt=1. If the counter reaches START_TIMEOUT_CYCLES -> ERROR(01).
  - SHIFT: on each fall_edge, bit_cnt increments. Edges 2..8 drive data bits 1..7; edge 9 drives parity; edge 10 releases data (stop bit) -> WAIT_ACK.
  - WAIT_ACK: on edge 11, sample filtered data. 0 -> WAIT_IDLE; 1 -> ERROR(11).
  - WAIT_IDLE: when filtered clk=1 and data=1 -> DONE.
  - DONE: tx_done=1 for 1 cycle -> IDLE.
  - ERROR: both oe=0, tx_error=1 for 1 cycle, err_code updated -> IDLE.
- Frame timeout: in SHIFT, WAIT_ACK and WAIT_IDLE, if the counter reaches FRAME_TIMEOUT_CYCLES -> ERROR(10).
- Data is driven LSB first. data_oe changes only in the cycle after fall_edge; it never changes while the filtered clock is high.
- Counter: a single 21-bit counter, saturating and never wrapping; it is cleared on every state change.
- Simultaneous events: a fall_edge in the same cycle as the timeout terminal count is treated as the timeout.
- tx_ready rises in the cycle after DONE or ERROR, so back-to-back sends are allowed.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, RTS, WAIT_START, SHIFT, WAIT_ACK, WAIT_IDLE, DONE, ERROR;
  - ERR_START=2'b01, ERR_FRAME=2'b10, ERR_NOACK=2'b11;
  - PS2_FRAME_EDGES=11;
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4.
- Sub-module ps2_line_sync: synchronizer, glitch filter and fall_edge strobe for both lines. It is shared with the keyboard receiver.

Test Plan:
1. Send 0xED; device model clocks at ~12 kHz and ACKs. Required: clk low 10000 cycles; data bits on edges 1..9 = 1,0,1,1,0,1,1,1,1 (parity 1); data released at edge 10; tx_done pulse; err_code stays 00.
2. Send 0x01 and 0x00. Required: parity bit 0 for 0x01 and 1 for 0x00; two back-to-back transfers; tx_ready low throughout each transfer.
3. Device never clocks after RTS. Required: tx_error with err_code=01 exactly 1500000 cycles after clock release; both oe=0.
4. Device stops after 5 edges. Required: err_code=10 exactly 200000 cycles after edge 1; lines released; next tx_valid accepted.
5. Device leaves data high on edge 11. Required: tx_error with err_code=11; no tx_done.
6. Reset asserted at edge 6 of a 0xFF send, plus 2-cycle glitches on ps2_clk_in. Required: oe outputs 0 in the same cycle as reset, no tx_done/tx_error pulse; glitches produce no bit advance.
